fetch_unit: RTL

- Instruction-fetch stage of the core: owns the PC, issues single-outstanding requests to instruction memory and queries the branch predictor with each returned instruction.
- Steers the next PC from the prediction and buffers {pc, instr, prediction} entries in a small FIFO feeding decode.
- Execute-stage redirects (mispredict, trap, fence) flush the buffer and restart fetch.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared opcode constants, fetch FSM state and decode-buffer entry layout
// for the fetch stage.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

  function automatic logic is_jump_opc(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage,
// so a pushed entry becomes visible on the cycle after the push.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (cnt == (AW+1)'(DEPTH));
  assign empty_o   = (cnt == '0);
  assign count_o   = cnt;
  assign rd_data_o = mem[rd_ptr];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests, consults the branch predictor and buffers entries for decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  bp_pc_o,
  output logic         bp_is_jump_o,
  input  logic         bp_taken_i,
  input  logic [31:0]  bp_target_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         id_valid_o,
  input  logic         id_ready_i,
  output logic [31:0]  id_instr_o,
  output logic [31:0]  id_pc_o,
  output logic         id_pred_taken_o,
  output logic [31:0]  id_pred_target_o,
  output fetch_state_t dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state;
  logic         run;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         xfer;
  logic         take;
  logic         push;
  logic         pop;

  // Handshakes: imem transfer = req & ack, with req/addr held until ack;
  // decode transfer = id_valid_o & id_ready_i, valid never depends on ready.
  assign imem_req_o   = run & ((state == DRAIN) | (fifo_count < CW'(FIFO_DEPTH)));
  assign imem_addr_o  = (state == DRAIN) ? drain_addr : pc;
  assign xfer         = imem_req_o & imem_ack_i & (state == FETCH);
  assign bp_pc_o      = pc;
  assign bp_is_jump_o = xfer & is_jump_opc(imem_rdata_i[6:0]);
  assign take         = bp_is_jump_o & bp_taken_i;
  assign push         = xfer & ~redirect_i & ~fifo_full;
  assign pop          = id_valid_o & id_ready_i & ~redirect_i;
  assign dbg_state_o  = state;

  always_comb begin
    push_entry             = '0;
    push_entry.pc          = pc;
    push_entry.instr       = imem_rdata_i;
    push_entry.pred_taken  = take;
    push_entry.pred_target = take ? bp_target_i : 32'h0;
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (redirect_i),
    .push_i   (push),
    .wr_data_i(push_entry),
    .pop_i    (pop),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign id_valid_o       = ~fifo_empty;
  assign id_instr_o       = head.instr;
  assign id_pc_o          = head.pc;
  assign id_pred_taken_o  = head.pred_taken;
  assign id_pred_target_o = head.pred_target;

  // run keeps the request low for the first cycle out of reset.
  // DRAIN absorbs the ack of a request abandoned by a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      run        <= 1'b0;
      pc         <= RESET_VECTOR;
      drain_addr <= RESET_VECTOR;
    end else begin
      run <= 1'b1;
      if (redirect_i) begin
        pc <= redirect_pc_i;
        if (state == FETCH && imem_req_o && !imem_ack_i) begin
          state      <= DRAIN;
          drain_addr <= pc;
        end else if (state == DRAIN && imem_ack_i) begin
          state <= FETCH;
        end
      end else if (state == DRAIN) begin
        if (imem_ack_i) state <= FETCH;
      end else if (xfer) begin
        pc <= take ? bp_target_i : pc + 32'd4;
      end
    end
  end

endmodule
